dma_addr_count_regfile: RTL and testbench

- Parametrised successor to the KF8237 address/count register set: N channels of base/current address and base/current word count, with configurable widths.
- Adds per-channel autoinitialize and sticky terminal-count status.
- Sits between the 8237-style bus/command decoder (byte-serial CPU access over an 8-bit internal bus) and the DMA timing FSM (next_word/transfer address).

---
 rtl/dma_addr_count_regfile.sv | 241 ++++++++++++++++++++++++
 tb/tb_dma_addr_count_regfile.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_addr_count_regfile.sv
// dma_addr_count_regfile: per-channel base/current address and word-count
// registers for an 8237-style DMA controller. The CPU reaches the registers
// one byte at a time over the 8-bit internal bus, using a shared byte
// pointer. The DMA timing FSM steps the selected channel with next_word.
// Terminal-count flags are sticky.
// Optional feature: define DMA_REGFILE_AUTOINIT_EN to honour autoinit_enable.
// When it is set, an underflowing step reloads current address/count from base.
module dma_addr_count_regfile #(
  parameter int CHANNELS    = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_clock_negedge,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  input  logic [CHANNELS-1:0]   write_address,
  input  logic [CHANNELS-1:0]   write_count,
  input  logic [CHANNELS-1:0]   read_address,
  input  logic [CHANNELS-1:0]   read_count,
  input  logic                  clear_byte_pointer,
  input  logic                  master_clear,
  input  logic [CHANNELS-1:0]   select,
  input  logic                  initialize,
  input  logic                  next_word,
  input  logic                  address_hold,
  input  logic                  address_decrement,
  input  logic [CHANNELS-1:0]   autoinit_enable,
  input  logic [CHANNELS-1:0]   tc_clear,
  output logic [ADDR_WIDTH-1:0] transfer_address,
  output logic                  underflow,
  output logic                  update_high_address,
  output logic [CHANNELS-1:0]   terminal_count
);

  localparam int ADDR_LANES  = ADDR_WIDTH / 8;
  localparam int COUNT_LANES = COUNT_WIDTH / 8;
  localparam int MAX_LANES   = (ADDR_LANES > COUNT_LANES) ? ADDR_LANES : COUNT_LANES;
  localparam int PTR_W       = (MAX_LANES > 1) ? $clog2(MAX_LANES) : 1;
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [ADDR_WIDTH-1:0]  base_addr_q  [CHANNELS];
  logic [ADDR_WIDTH-1:0]  base_addr_d  [CHANNELS];
  logic [ADDR_WIDTH-1:0]  cur_addr_q   [CHANNELS];
  logic [ADDR_WIDTH-1:0]  cur_addr_d   [CHANNELS];
  logic [COUNT_WIDTH-1:0] base_count_q [CHANNELS];
  logic [COUNT_WIDTH-1:0] base_count_d [CHANNELS];
  logic [COUNT_WIDTH-1:0] cur_count_q  [CHANNELS];
  logic [COUNT_WIDTH-1:0] cur_count_d  [CHANNELS];

  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [2*CHANNELS-1:0]   read_q, read_d;
  logic [ADDR_WIDTH-1:0]   transfer_address_q, transfer_address_d;
  logic [CHANNELS-1:0]     tc_q, tc_d;

  logic [CH_W-1:0]        sel_ch;
  logic [ADDR_WIDTH-1:0]  sel_addr, stepped_addr;
  logic [COUNT_WIDTH-1:0] sel_count;
  logic                   step_en, step_taken, sel_written, reload;
  logic                   rd_release, adv;
  logic [PTR_W-1:0]       last_lane;

  // Byte lane p of a register with the given number of lanes.
  // A lane outside the register reads as 0.
  function automatic logic [7:0] lane_get(input logic [31:0] v, input logic [PTR_W-1:0] p,
                                          input int lanes);
    logic [7:0] res;
    res = '0;
    for (int l = 0; l < 4; l++)
      if (l < lanes && p == PTR_W'(l)) res = v[l*8 +: 8];
    return res;
  endfunction

  // Replace byte lane p. A lane outside the register leaves it unchanged.
  function automatic logic [31:0] lane_put(input logic [31:0] v, input logic [PTR_W-1:0] p,
                                           input int lanes, input logic [7:0] d);
    logic [31:0] res;
    res = v;
    for (int l = 0; l < 4; l++)
      if (l < lanes && p == PTR_W'(l)) res[l*8 +: 8] = d;
    return res;
  endfunction

  // The lowest set select bit picks the transfer channel; no bit set picks channel 0.
  // NOTE: every combinational output gets a default before any condition, so no latch is inferred.
  always_comb begin
    sel_ch = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (select[i]) sel_ch = CH_W'(i);
  end

  assign sel_addr    = cur_addr_q[sel_ch];
  assign sel_count   = cur_count_q[sel_ch];
  assign underflow   = next_word & (sel_count == '0);
  assign step_en     = next_word & cpu_clock_negedge;
  assign sel_written = write_address[sel_ch] | write_count[sel_ch];
  // A CPU write or an initialize on the selected channel cancels the whole step.
  // That includes the terminal-count set.
  assign step_taken  = step_en & ~initialize & ~sel_written;

`ifdef DMA_REGFILE_AUTOINIT_EN
  assign reload = autoinit_enable[sel_ch] & underflow;
`else
  logic autoinit_unused;
  assign autoinit_unused = ^autoinit_enable;
  assign reload          = 1'b0;
`endif

  // Address the selected channel would move to on a step.
  always_comb begin
    stepped_addr = sel_addr;
    if (!address_hold)
      stepped_addr = address_decrement ? sel_addr - 1'b1 : sel_addr + 1'b1;
  end

  generate
    if (ADDR_WIDTH > 8) begin : g_high
      assign update_high_address =
        next_word & (stepped_addr[ADDR_WIDTH-1:8] != transfer_address_q[ADDR_WIDTH-1:8]);
    end else begin : g_no_high
      assign update_high_address = 1'b0;
    end
  endgenerate

  // CPU read mux: address strobes outrank count strobes; lower channels win.
  always_comb begin
    logic found;
    data_out = '0;
    found    = 1'b0;
    for (int i = 0; i < CHANNELS; i++)
      if (!found && read_address[i]) begin
        data_out = lane_get(32'(cur_addr_q[i]), ptr_q, ADDR_LANES);
        found    = 1'b1;
      end
    for (int i = 0; i < CHANNELS; i++)
      if (!found && read_count[i]) begin
        data_out = lane_get(32'(cur_count_q[i]), ptr_q, COUNT_LANES);
        found    = 1'b1;
      end
  end

  // Byte pointer: it steps on each write cycle. It also steps when a read strobe
  // that was active on the previous cycle changes value. The read case wraps on
  // the lane count of the register that was just read.
  always_comb begin
    rd_release = (read_q != '0) && ({read_count, read_address} != read_q);
    adv        = (write_address != '0) || (write_count != '0) || rd_release;
    if (write_address != '0)           last_lane = PTR_W'(ADDR_LANES - 1);
    else if (write_count != '0)        last_lane = PTR_W'(COUNT_LANES - 1);
    else if (read_q[CHANNELS-1:0] != '0) last_lane = PTR_W'(ADDR_LANES - 1);
    else                               last_lane = PTR_W'(COUNT_LANES - 1);
    ptr_d  = ptr_q;
    read_d = {read_count, read_address};
    if (master_clear) begin
      ptr_d  = '0;
      read_d = '0;
    end else if (clear_byte_pointer) begin
      ptr_d = '0;
    end else if (adv) begin
      ptr_d = (ptr_q >= last_lane) ? '0 : ptr_q + 1'b1;
    end
  end

  // Per-channel register updates in priority order:
  // master_clear, then CPU write, then initialize, then step.
  always_comb begin
    tc_d               = tc_q & ~tc_clear;
    transfer_address_d = cpu_clock_negedge ? sel_addr : transfer_address_q;
    for (int c = 0; c < CHANNELS; c++) begin
      base_addr_d[c]  = base_addr_q[c];
      cur_addr_d[c]   = cur_addr_q[c];
      base_count_d[c] = base_count_q[c];
      cur_count_d[c]  = cur_count_q[c];
      if (write_address[c] || write_count[c]) begin
        if (write_address[c]) begin
          base_addr_d[c] = ADDR_WIDTH'(lane_put(32'(base_addr_q[c]), ptr_q, ADDR_LANES, data_in));
          cur_addr_d[c]  = ADDR_WIDTH'(lane_put(32'(cur_addr_q[c]), ptr_q, ADDR_LANES, data_in));
        end
        if (write_count[c]) begin
          base_count_d[c] = COUNT_WIDTH'(lane_put(32'(base_count_q[c]), ptr_q, COUNT_LANES, data_in));
          cur_count_d[c]  = COUNT_WIDTH'(lane_put(32'(cur_count_q[c]), ptr_q, COUNT_LANES, data_in));
        end
      end else if (CH_W'(c) == sel_ch && initialize) begin
        cur_addr_d[c]  = base_addr_q[c];
        cur_count_d[c] = base_count_q[c];
      end else if (CH_W'(c) == sel_ch && step_taken) begin
        if (reload) begin
          cur_addr_d[c]  = base_addr_q[c];
          cur_count_d[c] = base_count_q[c];
        end else begin
          cur_addr_d[c]  = stepped_addr;
          cur_count_d[c] = sel_count - 1'b1;
        end
      end
    end
    if (step_taken && underflow) tc_d[sel_ch] = 1'b1;
    if (master_clear) begin
      tc_d               = '0;
      transfer_address_d = '0;
      for (int c = 0; c < CHANNELS; c++) begin
        base_addr_d[c]  = '0;
        cur_addr_d[c]   = '0;
        base_count_d[c] = '0;
        cur_count_d[c]  = '0;
      end
    end
  end

  // State registers with asynchronous reset.
  // NOTE: sequential state is assigned only with non-blocking (<=) assignments.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the register arrays are cleared by reset on purpose: software
      // expects every base/current register to read 0 after reset.
      for (int c = 0; c < CHANNELS; c++) begin
        base_addr_q[c]  <= '0;
        cur_addr_q[c]   <= '0;
        base_count_q[c] <= '0;
        cur_count_q[c]  <= '0;
      end
      ptr_q              <= '0;
      read_q             <= '0;
      transfer_address_q <= '0;
      tc_q               <= '0;
    end else begin
      base_addr_q        <= base_addr_d;
      cur_addr_q         <= cur_addr_d;
      base_count_q       <= base_count_d;
      cur_count_q        <= cur_count_d;
      ptr_q              <= ptr_d;
      read_q             <= read_d;
      transfer_address_q <= transfer_address_d;
      tc_q               <= tc_d;
    end
  end

  assign transfer_address = transfer_address_q;
  assign terminal_count   = tc_q;

endmodule

// File: tb/tb_dma_addr_count_regfile.sv
// Self-checking bench for dma_addr_count_regfile (4 channels, 24-bit address,
// 16-bit count). A behavioural model tracks every register as plain values.
// A negedge process compares all DUT outputs against the model on every cycle.
// Directed sections pin the model with hand-computed literals, and a random
// phase follows them.
module tb_dma_addr_count_regfile;
  localparam int CH = 4;
  localparam int AW = 24;
  localparam int CW = 16;
  localparam int AL = AW / 8;
  localparam int CL = CW / 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_clock_negedge;
  logic [7:0]    data_in;
  logic [7:0]    data_out;
  logic [CH-1:0] write_address, write_count, read_address, read_count;
  logic          clear_byte_pointer, master_clear;
  logic [CH-1:0] select;
  logic          initialize, next_word, address_hold, address_decrement;
  logic [CH-1:0] autoinit_enable, tc_clear;
  logic [AW-1:0] transfer_address;
  logic          underflow, update_high_address;
  logic [CH-1:0] terminal_count;

  dma_addr_count_regfile #(.CHANNELS(CH), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .cpu_clock_negedge(cpu_clock_negedge),
    .data_in(data_in), .data_out(data_out),
    .write_address(write_address), .write_count(write_count),
    .read_address(read_address), .read_count(read_count),
    .clear_byte_pointer(clear_byte_pointer), .master_clear(master_clear),
    .select(select), .initialize(initialize), .next_word(next_word),
    .address_hold(address_hold), .address_decrement(address_decrement),
    .autoinit_enable(autoinit_enable), .tc_clear(tc_clear),
    .transfer_address(transfer_address), .underflow(underflow),
    .update_high_address(update_high_address), .terminal_count(terminal_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [AW-1:0] m_base_a [CH];
  logic [AW-1:0] m_cur_a  [CH];
  logic [CW-1:0] m_base_c [CH];
  logic [CW-1:0] m_cur_c  [CH];
  logic [AW-1:0] m_ta;
  logic [CH-1:0] m_tc, m_prev_ra, m_prev_rc;
  int            m_ptr;

  function automatic int m_sel();
    for (int i = 0; i < CH; i++) if (select[i]) return i;
    return 0;
  endfunction

  function automatic logic [AW-1:0] m_stepped();
    int s = m_sel();
    if (address_hold) return m_cur_a[s];
    if (address_decrement) return m_cur_a[s] - 1'b1;
    return m_cur_a[s] + 1'b1;
  endfunction

  function automatic logic m_underflow();
    return next_word && (m_cur_c[m_sel()] == 0);
  endfunction

  function automatic logic m_uha();
    return next_word && ((m_stepped() >> 8) != (m_ta >> 8));
  endfunction

  function automatic logic [7:0] m_data_out();
    for (int i = 0; i < CH; i++)
      if (read_address[i]) return (m_ptr < AL) ? 8'(m_cur_a[i] >> (8 * m_ptr)) : 8'h00;
    for (int i = 0; i < CH; i++)
      if (read_count[i]) return (m_ptr < CL) ? 8'(m_cur_c[i] >> (8 * m_ptr)) : 8'h00;
    return 8'h00;
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] v, input int p, input logic [7:0] d);
    return (v & ~(32'hFF << (8 * p))) | (32'(d) << (8 * p));
  endfunction

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      m_base_a[c] = '0; m_cur_a[c] = '0; m_base_c[c] = '0; m_cur_c[c] = '0;
    end
    m_ta = '0; m_tc = '0; m_prev_ra = '0; m_prev_rc = '0; m_ptr = 0;
  endtask

  task automatic model_step();
    int s, lanes;
    logic uf, rel, rl;
    logic [AW-1:0] st, nta;
    if (master_clear) begin
      model_clear();
      return;
    end
    s   = m_sel();
    uf  = m_underflow();
    st  = m_stepped();
    nta = cpu_clock_negedge ? m_cur_a[s] : m_ta;
    m_tc = m_tc & ~tc_clear;
    for (int c = 0; c < CH; c++) begin
      if (write_address[c] || write_count[c]) begin
        if (write_address[c] && m_ptr < AL) begin
          m_base_a[c] = AW'(put_byte(32'(m_base_a[c]), m_ptr, data_in));
          m_cur_a[c]  = AW'(put_byte(32'(m_cur_a[c]), m_ptr, data_in));
        end
        if (write_count[c] && m_ptr < CL) begin
          m_base_c[c] = CW'(put_byte(32'(m_base_c[c]), m_ptr, data_in));
          m_cur_c[c]  = CW'(put_byte(32'(m_cur_c[c]), m_ptr, data_in));
        end
      end else if (c == s && initialize) begin
        m_cur_a[c] = m_base_a[c];
        m_cur_c[c] = m_base_c[c];
      end else if (c == s && next_word && cpu_clock_negedge) begin
        rl = 1'b0;
`ifdef DMA_REGFILE_AUTOINIT_EN
        rl = uf && autoinit_enable[c];
`endif
        if (uf) m_tc[c] = 1'b1;
        if (rl) begin
          m_cur_a[c] = m_base_a[c];
          m_cur_c[c] = m_base_c[c];
        end else begin
          m_cur_a[c] = st;
          m_cur_c[c] = m_cur_c[c] - 1'b1;
        end
      end
    end
    rel = ((m_prev_ra | m_prev_rc) != 0) && ((read_address != m_prev_ra) || (read_count != m_prev_rc));
    if (clear_byte_pointer) m_ptr = 0;
    else if (write_address != 0 || write_count != 0 || rel) begin
      lanes = (write_address != 0) ? AL : (write_count != 0) ? CL : (m_prev_ra != 0) ? AL : CL;
      m_ptr = (m_ptr >= lanes - 1) ? 0 : m_ptr + 1;
    end
    m_prev_ra = read_address;
    m_prev_rc = read_count;
    m_ta      = nta;
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) model_clear();
    else model_step();
  end

  // Compare every DUT output against the model in mid-cycle.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("data_out", 32'(data_out), 32'(m_data_out()));
      check("transfer_address", 32'(transfer_address), 32'(m_ta));
      check("underflow", 32'(underflow), 32'(m_underflow()));
      check("update_high_address", 32'(update_high_address), 32'(m_uha()));
      check("terminal_count", 32'(terminal_count), 32'(m_tc));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    write_address = '0; write_count = '0; read_address = '0; read_count = '0;
    clear_byte_pointer = 1'b0; master_clear = 1'b0; initialize = 1'b0;
    next_word = 1'b0; cpu_clock_negedge = 1'b0; tc_clear = '0;
  endtask

  task automatic clr_ptr();
    idle();
    clear_byte_pointer = 1'b1;
    tick();
    idle();
  endtask

  task automatic wr_addr(input int ch, input logic [AW-1:0] v);
    clr_ptr();
    for (int l = 0; l < AL; l++) begin
      idle();
      write_address = CH'(1 << ch);
      data_in = v[l*8 +: 8];
      tick();
    end
    idle();
  endtask

  task automatic wr_cnt(input int ch, input logic [CW-1:0] v);
    clr_ptr();
    for (int l = 0; l < CL; l++) begin
      idle();
      write_count = CH'(1 << ch);
      data_in = v[l*8 +: 8];
      tick();
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    data_in = '0; select = '0; address_hold = 1'b0; address_decrement = 1'b0;
    autoinit_enable = '0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    read_address = 4'b0001;
    #1;
    check("reset_ta", 32'(transfer_address), 32'h0);
    check("reset_tc", 32'(terminal_count), 32'h0);
    check("reset_data_out", 32'(data_out), 32'h0);
    idle();
    reset = 1'b0;
    cmp_en = 1'b1;
    tick();

    // Channel 1 address write and byte-serial read-back.
    wr_addr(1, 24'h001234);
    clr_ptr();
    read_address = 4'b0010;
    #1 check("rd_ch1_lo", 32'(data_out), 32'h34);
    tick();
    read_address = 4'b0000;
    tick();
    read_address = 4'b0010;
    #1 check("rd_ch1_hi", 32'(data_out), 32'h12);
    tick();
    idle();
    tick();

    // Three-lane address on channel 0, then a fourth write wraps to lane 0.
    wr_addr(0, 24'h030201);
    select = 4'b0001;
    cpu_clock_negedge = 1'b1;
    tick();
    check("ta_ch0_3lanes", 32'(transfer_address), 32'h030201);
    idle();
    write_address = 4'b0001;
    data_in = 8'h04;
    tick();
    idle();
    cpu_clock_negedge = 1'b1;
    tick();
    check("ta_ch0_wrap", 32'(transfer_address), 32'h030204);
    idle();

    // Channel 2: count 1, address 0x00FF, incrementing steps.
    wr_cnt(2, 16'h0001);
    wr_addr(2, 24'h0000FF);
    select = 4'b0100;
    cpu_clock_negedge = 1'b1;
    tick();
    next_word = 1'b1;
    cpu_clock_negedge = 1'b1;
    #1;
    check("ch2_uha_ff_to_100", 32'(update_high_address), 32'h1);
    check("ch2_no_uf_first", 32'(underflow), 32'h0);
    tick();
    #1 check("ch2_uf_at_zero", 32'(underflow), 32'h1);
    tick();
    check("ch2_tc_set", 32'(terminal_count), 32'b0100);
    check("ch2_ta_100", 32'(transfer_address), 32'h000100);
    check("ch2_no_uf_ffff", 32'(underflow), 32'h0);
    tick();
    clr_ptr();
    read_count = 4'b0100;
    #1 check("ch2_count_lo_fe", 32'(data_out), 32'hFE);
    tick();
    idle();
    tick();

    // Channel 3: decrementing step from count 0 with autoinit requested.
    autoinit_enable = 4'b1000;
    wr_addr(3, 24'h001000);
    wr_cnt(3, 16'h0000);
    select = 4'b1000;
    address_decrement = 1'b1;
    next_word = 1'b1;
    cpu_clock_negedge = 1'b1;
    #1 check("ch3_uf", 32'(underflow), 32'h1);
    tick();
    idle();
    cpu_clock_negedge = 1'b1;
    tick();
`ifdef DMA_REGFILE_AUTOINIT_EN
    check("ch3_addr_after_uf", 32'(transfer_address), 32'h001000);
`else
    check("ch3_addr_after_uf", 32'(transfer_address), 32'h000FFF);
`endif
    check("ch3_tc", 32'(terminal_count), 32'b1100);
    clr_ptr();
    read_count = 4'b1000;
`ifdef DMA_REGFILE_AUTOINIT_EN
    #1 check("ch3_count_lo", 32'(data_out), 32'h00);
`else
    #1 check("ch3_count_lo", 32'(data_out), 32'hFF);
`endif
    tick();
    idle();
    address_decrement = 1'b0;
    autoinit_enable = '0;
    tick();

    // A CPU write beats a same-cycle step on channel 0.
    clr_ptr();
    select = 4'b0001;
    write_address = 4'b0001;
    data_in = 8'h55;
    next_word = 1'b1;
    cpu_clock_negedge = 1'b1;
    tick();
    idle();
    cpu_clock_negedge = 1'b1;
    tick();
    check("write_beats_step", 32'(transfer_address), 32'h030255);
    idle();

    // A terminal-count set beats tc_clear in the same cycle.
    wr_cnt(1, 16'h0000);
    select = 4'b0010;
    next_word = 1'b1;
    cpu_clock_negedge = 1'b1;
    tc_clear = 4'b0110;
    tick();
    check("tc_set_beats_clear", 32'(terminal_count), 32'b1010);
    idle();
    tc_clear = 4'b1111;
    tick();
    check("tc_clear_all", 32'(terminal_count), 32'h0);
    idle();

    // Asynchronous reset in mid-transfer.
    select = 4'b0001;
    read_address = 4'b0001;
    cpu_clock_negedge = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("async_rst_ta", 32'(transfer_address), 32'h0);
    check("async_rst_tc", 32'(terminal_count), 32'h0);
    check("async_rst_data", 32'(data_out), 32'h0);
    tick();
    reset = 1'b0;
    idle();
    tick();

    // master_clear takes effect at the next edge.
    wr_addr(1, 24'hABCDEF);
    select = 4'b0010;
    cpu_clock_negedge = 1'b1;
    tick();
    check("pre_mclr_ta", 32'(transfer_address), 32'hABCDEF);
    idle();
    master_clear = 1'b1;
    read_address = 4'b0010;
    tick();
    check("mclr_ta", 32'(transfer_address), 32'h0);
    check("mclr_data", 32'(data_out), 32'h0);
    idle();
    tick();

    // Randomised traffic checked cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        wr_cnt($urandom_range(0, CH - 1), CW'($urandom_range(0, 3)));
      end else begin
        idle();
        select             = CH'($urandom);
        next_word          = 1'($urandom);
        cpu_clock_negedge  = 1'($urandom);
        address_hold       = ($urandom_range(0, 3) == 0);
        address_decrement  = 1'($urandom);
        autoinit_enable    = CH'($urandom);
        initialize         = ($urandom_range(0, 15) == 0);
        tc_clear           = ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0;
        clear_byte_pointer = ($urandom_range(0, 15) == 0);
        master_clear       = ($urandom_range(0, 499) == 0);
        data_in            = 8'($urandom);
        if ($urandom_range(0, 7) == 0) write_address = CH'(1 << $urandom_range(0, CH - 1));
        if ($urandom_range(0, 2) == 0) read_address = CH'(1 << $urandom_range(0, CH - 1));
        tick();
      end
    end
    idle();
    tick();
    tick();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
